// File: rtl/alu_seq_core.sv
// Handshaked ALU core: registered single-cycle ops, multi-cycle variable shifts,
// and an iterative shift-add multiplier. One operation in flight at a time.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SLT = 4'd6, OP_SLL = 4'd7,
    OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10
  } op_e;

  state_e             state_q, state_d;
  logic               accept, is_shift, is_multi, last;
  logic [SHW-1:0]     amt, cnt_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   s_res, sh_q, sh_next, mplier_q, fin_res;
  logic               s_cout, s_ovf, s_ill, sh_out, fin_cout, fin_ovf, fin_ill, load_out;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_next;

  assign amt      = b[SHW-1:0];
  assign is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);
  assign is_multi = (is_shift && amt != '0) || (opcode == OP_MUL);
  assign in_ready = (state_q == IDLE || (state_q == DONE && out_ready)) && !rst;
  assign accept   = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign last     = (cnt_q == '0);

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum    = '0;
    s_res  = '0;
    s_cout = 1'b0;
    s_ovf  = 1'b0;
    s_ill  = 1'b0;
    case (opcode)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        s_res  = sum[WIDTH-1:0];
        s_cout = sum[WIDTH];
        s_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(!cin);
        s_res  = sum[WIDTH-1:0];
        s_cout = sum[WIDTH];
        s_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_NOT:  s_res = ~a;
      OP_SLT:  s_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_SLL, OP_SRL, OP_SRA: s_res = a;  // only reached here with a zero shift amount
      OP_MUL:  s_res = '0;
      default: s_ill = 1'b1;
    endcase
  end

  // One iteration of the shift / multiply loop.
  always_comb begin
    sh_next = sh_q;
    sh_out  = 1'b0;
    case (op_q)
      OP_SLL: begin sh_next = {sh_q[WIDTH-2:0], 1'b0};        sh_out = sh_q[WIDTH-1]; end
      OP_SRL: begin sh_next = {1'b0, sh_q[WIDTH-1:1]};        sh_out = sh_q[0];       end
      OP_SRA: begin sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; sh_out = sh_q[0];     end
      default: ;
    endcase
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    load_out = 1'b0;
    fin_res  = s_res;
    fin_cout = s_cout;
    fin_ovf  = s_ovf;
    fin_ill  = s_ill;
    if (accept && !is_multi) begin
      load_out = 1'b1;
    end else if (state_q == EXEC && last) begin
      load_out = 1'b1;
      fin_ill  = 1'b0;
      if (op_q == OP_MUL) begin
        fin_res  = acc_next[WIDTH-1:0];
        fin_cout = 1'b0;
        fin_ovf  = |acc_next[2*WIDTH-1:WIDTH];
      end else begin
        fin_res  = sh_next;
        fin_cout = sh_out;
        fin_ovf  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)                             state_d = is_multi ? EXEC : DONE;
        else if (state_q == DONE && out_ready)  state_d = IDLE;
      end
      EXEC:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (load_out) begin
      result   <= fin_res;
      cout     <= fin_cout;
      zero     <= (fin_res == '0);
      negative <= fin_res[WIDTH-1];
      overflow <= fin_ovf;
      illegal  <= fin_ill;
    end
  end

  // NOTE: working registers carry no reset; they are always reloaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= opcode;
      sh_q     <= a;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= (opcode == OP_MUL) ? '1 : amt - SHW'(1);
    end else if (state_q == EXEC) begin
      sh_q     <= sh_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
      cnt_q    <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8): an arithmetic reference model queues
// expected responses at issue; an independent monitor pops them as results are consumed.
module tb_alu_seq_core;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic         cout, zero, neg, ovf, ill;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   opcode;
  logic         cout, zero, negative, overflow, illegal;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   bp_rand = 0;
  exp_t sb[$];

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .negative(negative), .overflow(overflow), .illegal(illegal)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    int ux, uy, sx, sy, n, s;
    e = '{default: 0};
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    n  = int'(y[2:0]);
    e.lat = 1;
    case (op)
      4'd0: begin
        s = ux + uy + int'(c);  e.result = s[7:0];  e.cout = (s > 255);
        s = sx + sy + int'(c);  e.ovf = (s > 127) || (s < -128);
      end
      4'd1: begin
        s = ux - uy - int'(c);  e.result = s[7:0];  e.cout = (s >= 0);
        s = sx - sy - int'(c);  e.ovf = (s > 127) || (s < -128);
      end
      4'd2: e.result = x & y;
      4'd3: e.result = x | y;
      4'd4: e.result = x ^ y;
      4'd5: e.result = ~x;
      4'd6: e.result = (sx < sy) ? 8'd1 : 8'd0;
      4'd7: begin
        s = ux << n;  e.result = s[7:0];  e.cout = (n > 0) ? s[8] : 1'b0;  e.lat = n + 1;
      end
      4'd8: begin
        s = ux >> n;  e.result = s[7:0];  e.cout = (n > 0) ? x[n-1] : 1'b0;  e.lat = n + 1;
      end
      4'd9: begin
        s = sx >>> n; e.result = s[7:0];  e.cout = (n > 0) ? x[n-1] : 1'b0;  e.lat = n + 1;
      end
      4'd10: begin
        s = ux * uy;  e.result = s[7:0];  e.ovf = ((s >> 8) != 0);  e.lat = W + 1;
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.result == 8'd0);
    e.neg  = e.result[7];
    return e;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic);
    int   waited = 0;
    exp_t e;
    opcode = op; a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(op, ia, ib, ic);
    e.acc_cyc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); opcode = 4'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares the presented response against the queue head every cycle it is valid.
  initial begin
    bit   fresh = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        fresh = 1'b1;
        continue;
      end
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'd0);
        continue;
      end
      e = sb[0];
      if (fresh) begin
        check("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        fresh = 1'b0;
      end
      check("result",   32'(result),   32'(e.result));
      check("cout",     32'(cout),     32'(e.cout));
      check("zero",     32'(zero),     32'(e.zero));
      check("negative", 32'(negative), 32'(e.neg));
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("illegal",  32'(illegal),  32'(e.ill));
      if (!out_ready) check("in_ready_bp", 32'(in_ready), 32'd0);
      else begin
        void'(sb.pop_front());
        fresh = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags", 32'({cout, zero, negative, overflow, illegal}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back.
    issue(4'd0,  8'h7F, 8'h01, 1'b0);
    issue(4'd1,  8'h00, 8'h01, 1'b0);
    issue(4'd7,  8'h81, 8'h03, 1'b0);
    issue(4'd9,  8'h90, 8'h02, 1'b0);
    issue(4'd7,  8'hA5, 8'h00, 1'b0);
    issue(4'd10, 8'h10, 8'h20, 1'b0);
    issue(4'd10, 8'h0B, 8'h0D, 1'b0);
    issue(4'd6,  8'h80, 8'h01, 1'b0);
    issue(4'hC,  8'h12, 8'h34, 1'b1);
    issue(4'd8,  8'hC3, 8'h07, 1'b0);
    issue(4'd9,  8'h7F, 8'h05, 1'b0);
    issue(4'd0,  8'hFF, 8'h00, 1'b1);
    issue(4'd1,  8'h80, 8'h01, 1'b1);
    issue(4'd5,  8'hFF, 8'h00, 1'b0);
    drain();

    // Backpressure, then a result release overlapping the next accept.
    out_ready = 1'b0;
    issue(4'd0, 8'h3C, 8'h42, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_hold_valid",  32'(out_valid), 32'd1);
    check("bp_hold_result", 32'(result),    32'h7F);
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd4, 8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    check("b2b_valid",  32'(out_valid), 32'd1);
    check("b2b_result", 32'(result),    32'hFF);
    @(posedge clk);
    #1;
    drain();

    // Reset during a multiply discards it.
    issue(4'd10, 8'h37, 8'h5B, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result",    32'(result),    32'd0);
    check("midrst_flags", 32'({cout, zero, negative, overflow, illegal}), 32'd0);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer backpressure and idle gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    bp_rand = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Keeps the ADD/SUB/AND/OR/XOR/NOT/SLT/SLL opcode map and cout/zero/negative/overflow flags.
- Adds a generic WIDTH, valid/ready flow control, registered outputs, variable-amount multi-cycle shifts (SLL/SRL/SRA) and an iterative shift-add multiplier.
- Sits between the operand issue logic and the writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  core can accept; combinational: (state==IDLE || (state==DONE && out_ready)) && !rst.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
- opcode  in  4  operation select.
- cin  in  1  carry/borrow in (ADD/SUB only).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- cout  out  1  carry out / last bit shifted out.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow (ADD/SUB) or product high half nonzero (MUL).
- illegal  out  1  opcode not defined.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; out_valid, result, cout, zero, negative, overflow, illegal all 0. Any in-flight operation is aborted and discarded. in_ready=0 while rst=1.
- Accept when in_valid && in_ready. a, b, opcode and cin are latched; inputs are ignored afterwards.
- Opcodes:
  - 0000 ADD: a+b+cin.
  - 0001 SUB: a+~b+!cin, i.e. a-b-cin; cout=1 means no borrow.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT a.
  - 0110 SLT: signed a<b → 1, else 0; zero-extended.
  - 0111 SLL.
  - 1000 SRL.
  - 1001 SRA.
  - 1010 MUL: low WIDTH bits of unsigned a*b.
  - 1011–1111: illegal; result=0, zero=1, illegal=1, other flags 0.
- Flags:
  - ADD/SUB: overflow = operands' sign relation (same for ADD, differing for SUB) with result sign differing.
  - SLT: cout=0, overflow=0. Logic ops and NOT: cout=0, overflow=0.
  - Shifts: cout = last bit shifted out; 0 if the shift amount is 0. overflow=0.
  - MUL: cout=0.
  - zero and negative are always derived from the final result.
- FSM IDLE → EXEC → DONE:
  - IDLE: on accept, single-cycle ops (including illegal, and shifts with amount 0) go straight to DONE with outputs registered. Shifts with amount n>0 and MUL go to EXEC.
  - EXEC, shift: one bit position per cycle, n cycles, down-counter.
  - EXEC, MUL: WIDTH cycles; each cycle conditionally adds a shifted multiplicand into a 2*WIDTH accumulator.
  - EXEC: at the end of the last EXEC cycle, outputs are registered and state goes to DONE.
  - DONE: out_valid=1. result/flags are held stable while out_ready=0.
  - DONE: on out_ready=1 with no new accept → IDLE, out_valid=0 next cycle. On out_ready=1 with a new accept → same as the IDLE accept path (back-to-back issue, no bubble).
- Latency (accept edge to out_valid=1):
  - 1 cycle for single-cycle ops.
  - n+1 cycles for shifts by n.
  - WIDTH+1 cycles for MUL.
- in_valid during EXEC: ignored (in_ready=0); the requester must hold its request.
- Widths: internal adder is WIDTH+1 bits; MUL accumulator is 2*WIDTH bits; shift counter is SHW bits.

Test Plan (WIDTH=8):
- ADD a=8'h7F, b=8'h01, cin=0 → result 8'h80, overflow=1, negative=1, cout=0, zero=0; out_valid 1 cycle after accept. SUB a=8'h00, b=8'h01, cin=0 → 8'hFF, cout=0, negative=1, overflow=0.
- SLL a=8'h81, b=3 → 8'h08, cout=0, out_valid 4 cycles after accept. SRA a=8'h90, b=2 → 8'hE4, negative=1, cout=0. SLL with b=0 → result=a, latency 1.
- MUL a=8'h10, b=8'h20 → result 8'h00, zero=1, overflow=1, latency 9. MUL a=8'h0B, b=8'h0D → 8'h8F, overflow=0.
- Backpressure: finish an ADD, hold out_ready=0 for 5 cycles → out_valid=1 and result/flags stable, in_ready=0. Then raise out_ready together with in_valid for an XOR 8'hAA^8'h55 → XOR accepted that cycle; next cycle result=8'hFF, out_valid=1.
- Reset mid-MUL (rst=1 for 1 cycle, 3 cycles after accept) → next cycle out_valid=0, all outputs 0; in_ready=1 once rst=0; no stale result ever appears.
- SLT a=8'h80, b=8'h01 → 1. Illegal opcode 4'hC → result 0, zero=1, illegal=1, latency 1.
